pipeline_hazard_ctrl: RTL and testbench

//  Sequencer for the 5-stage MIPS pipeline (IF/ID, ID/EX(DX), EX/MEM(XM), MEM/WB(MW)).

---
 rtl/mips_pipe_pkg.sv | 30 +++
 rtl/load_use_detect.sv | 24 ++
 rtl/pipeline_hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared constants for the 5-stage MIPS pipeline control slice.
// Holds FSM encodings, opcodes and the stage-control bundle.
package mips_pipe_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_ERROR    = 2'd2;

    localparam logic [5:0] OP_R   = 6'd0;
    localparam logic [5:0] OP_LW  = 6'd35;
    localparam logic [5:0] OP_SW  = 6'd43;
    localparam logic [5:0] OP_BEQ = 6'd4;
    localparam logic [5:0] OP_BNE = 6'd5;
    localparam logic [5:0] OP_J   = 6'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_we;
        logic pc_sel;
        logic fd_we;
        logic fd_flush;
        logic dx_we;
        logic dx_flush;
        logic xm_we;
        logic mw_bubble;
        logic mem_req;
    } stage_ctl_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard term for the instruction in ID.
// Ports: id_rs/id_rt/id_uses_rt (ID sources), dx_memread/dx_rd (EX lw), lu.
module load_use_detect
    import mips_pipe_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       dx_memread,
    input  logic [4:0] dx_rd,
    output logic       lu
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = (dx_rd == id_rs);
    assign w_rt_hit = id_uses_rt && (dx_rd == id_rt);

    // $zero is never a real producer, so a lw to r0 cannot hazard.
    assign lu = dx_memread && (dx_rd != REG_ZERO)
             && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: stage enables/flushes for load-use, redirect, mem wait.
// Ports: clk, rst (async active-low), hazard inputs, stage controls, counters.
module pipeline_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             dx_memread,
    input  logic [4:0]       dx_rd,
    input  logic             dx_br_taken,
    input  logic             dx_jump,
    input  logic             xm_memop,
    input  logic             mem_ack,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             fd_we,
    output logic             fd_flush,
    output logic             dx_we,
    output logic             dx_flush,
    output logic             xm_we,
    output logic             mw_bubble,
    output logic             mem_req,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [WC_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [1:0]       w_state_nxt;
    logic [WC_W-1:0]  w_wait_nxt;
    logic             w_lu;
    logic             w_redir;
    logic             w_adv;
    logic             w_err;
    stage_ctl_t       w_ctl;

    load_use_detect u_lu (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .dx_memread (dx_memread),
        .dx_rd      (dx_rd),
        .lu         (w_lu)
    );

    assign w_redir = dx_br_taken | dx_jump;

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_adv       = 1'b0;
        w_err       = 1'b0;
        w_ctl       = '0;

        case (r_state)
            ST_RUN: begin
                w_ctl.mem_req = xm_memop;
                if (xm_memop && !mem_ack) begin
                    w_ctl.mw_bubble = 1'b1;
                    w_state_nxt     = ST_MEM_WAIT;
                end else begin
                    w_adv = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                w_ctl.mem_req = 1'b1;
                if (mem_ack) begin
                    w_adv       = 1'b1;
                    w_state_nxt = ST_RUN;
                    w_wait_nxt  = '0;
                end else begin
                    w_ctl.mw_bubble = 1'b1;
                    if (r_wait_cnt == WC_LAST) begin
                        w_state_nxt = ST_ERROR;
                        w_wait_nxt  = '0;
                    end else begin
                        w_wait_nxt = r_wait_cnt + 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                w_err = 1'b1;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_wait_nxt  = '0;
            end
        endcase

        // Redirect wins over load-use: the stalled ID instr is wrong-path.
        if (w_adv) begin
            if (w_redir) begin
                w_ctl.pc_we    = 1'b1;
                w_ctl.pc_sel   = 1'b1;
                w_ctl.fd_we    = 1'b1;
                w_ctl.fd_flush = 1'b1;
                w_ctl.dx_we    = 1'b1;
                w_ctl.dx_flush = 1'b1;
                w_ctl.xm_we    = 1'b1;
            end else if (w_lu) begin
                w_ctl.dx_we    = 1'b1;
                w_ctl.dx_flush = 1'b1;
                w_ctl.xm_we    = 1'b1;
            end else begin
                w_ctl.pc_we = 1'b1;
                w_ctl.fd_we = 1'b1;
                w_ctl.dx_we = 1'b1;
                w_ctl.xm_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_ctl.pc_we && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_adv && w_redir && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    // Gating with rst freezes the pipe combinationally while in reset,
    // so a live xm_memop cannot keep mem_req up.
    assign pc_we     = rst & w_ctl.pc_we;
    assign pc_sel    = rst & w_ctl.pc_sel;
    assign fd_we     = rst & w_ctl.fd_we;
    assign fd_flush  = rst & w_ctl.fd_flush;
    assign dx_we     = rst & w_ctl.dx_we;
    assign dx_flush  = rst & w_ctl.dx_flush;
    assign xm_we     = rst & w_ctl.xm_we;
    assign mw_bubble = rst & w_ctl.mw_bubble;
    assign mem_req   = rst & w_ctl.mem_req;
    assign mem_err   = rst & w_err;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with directed vectors.
// Driver pushes expected controls/counters; monitor pops and compares.
module tb_pipeline_hazard_ctrl;

    localparam logic [9:0] C_RST = 10'b0000000000;
    localparam logic [9:0] C_ADV = 10'b1010101000;
    localparam logic [9:0] C_ADR = 10'b1010101010;
    localparam logic [9:0] C_LU  = 10'b0000111000;
    localparam logic [9:0] C_RED = 10'b1111111000;
    localparam logic [9:0] C_RDR = 10'b1111111010;
    localparam logic [9:0] C_FRZ = 10'b0000000110;
    localparam logic [9:0] C_ERR = 10'b0000000001;

    typedef struct {
        logic [9:0] ctl;
        int         st;
        int         fl;
        bit         chk;
        int         id;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic       id_uses_rt = 1'b0;
    logic       dx_memread = 1'b0;
    logic [4:0] dx_rd = '0;
    logic       dx_br_taken = 1'b0;
    logic       dx_jump = 1'b0;
    logic       xm_memop = 1'b0;
    logic       mem_ack = 1'b0;
    logic       pc_we, pc_sel, fd_we, fd_flush, dx_we, dx_flush;
    logic       xm_we, mw_bubble, mem_req, mem_err;
    logic [3:0] stall_cnt, flush_cnt;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   nstep = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .dx_memread(dx_memread), .dx_rd(dx_rd),
        .dx_br_taken(dx_br_taken), .dx_jump(dx_jump),
        .xm_memop(xm_memop), .mem_ack(mem_ack),
        .pc_we(pc_we), .pc_sel(pc_sel), .fd_we(fd_we),
        .fd_flush(fd_flush), .dx_we(dx_we), .dx_flush(dx_flush),
        .xm_we(xm_we), .mw_bubble(mw_bubble), .mem_req(mem_req),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic step(
        input logic       rn,
        input logic [4:0] rs, input logic [4:0] rt, input logic ut,
        input logic       mr, input logic [4:0] rd,
        input logic       br, input logic jp,
        input logic       mo, input logic ak,
        input logic [9:0] ctl, input int st, input int fl, input bit chk
    );
        exp_t e;
        @(negedge clk);
        rst = rn;
        id_rs = rs; id_rt = rt; id_uses_rt = ut;
        dx_memread = mr; dx_rd = rd;
        dx_br_taken = br; dx_jump = jp;
        xm_memop = mo; mem_ack = ak;
        e.ctl = ctl; e.st = st; e.fl = fl; e.chk = chk; e.id = nstep;
        q.push_back(e);
        nstep++;
    endtask

    task automatic idle(input logic [9:0] ctl, input int st, input int fl);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ctl, st, fl, 1);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0, 1);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [9:0] got;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                got = {pc_we, pc_sel, fd_we, fd_flush, dx_we, dx_flush,
                       xm_we, mw_bubble, mem_req, mem_err};
                checks++;
                if (got !== e.ctl) begin
                    errors++;
                    $display("FAIL ctl step %0d: got %b required %b",
                             e.id, got, e.ctl);
                end
                if (e.chk) begin
                    checks++;
                    if (stall_cnt !== 4'(e.st) || flush_cnt !== 4'(e.fl)) begin
                        errors++;
                        $display("FAIL cnt step %0d: got st=%0d fl=%0d required st=%0d fl=%0d",
                                 e.id, stall_cnt, flush_cnt, e.st, e.fl);
                    end
                end
            end
        end
    end

    initial begin : driver
        // Reset state
        do_reset();

        // 1: load-use on rs, then rt; r0 and unused rt never stall
        step(1, 2, 0, 0, 1, 2, 0, 0, 0, 0, C_LU, 0, 0, 1);
        idle(C_ADV, 1, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, C_ADV, 1, 0, 1);
        step(1, 5, 2, 1, 1, 2, 0, 0, 0, 0, C_LU, 1, 0, 1);
        idle(C_ADV, 2, 0);
        step(1, 5, 2, 0, 1, 2, 0, 0, 0, 0, C_ADV, 2, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_ADV, 2, 0, 1);
        idle(C_ADV, 2, 0);

        // 2: branch overrides load-use, then a jump
        do_reset();
        step(1, 2, 0, 0, 1, 2, 1, 0, 0, 0, C_RED, 0, 0, 1);
        idle(C_ADV, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_RED, 0, 1, 1);
        idle(C_ADV, 0, 2);

        // 3: mem ack after 3 wait cycles
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 1, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 2, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_ADR, 3, 0, 1);
        idle(C_ADV, 3, 0);

        // 4: timeout into ERROR, late ack ignored, reset clears
        do_reset();
        for (int i = 0; i < 16; i++)
            step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_ERR, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_ERR, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ERR, 0, 0, 0);
        do_reset();
        idle(C_ADV, 0, 0);

        // 5: jump held through mem wait redirects only on ack
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ, 1, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_RDR, 2, 0, 1);
        idle(C_ADV, 2, 1);

        // 6: stall counter saturates, async reset mid-wait
        do_reset();
        for (int i = 0; i < 20; i++)
            step(1, 3, 0, 0, 1, 3, 0, 0, 0, 0, C_LU, (i > 15) ? 15 : i, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 15, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 15, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RST, 0, 0, 1);
        idle(C_ADV, 0, 0);

        @(negedge clk);
        #5;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
